pcie_cpl_tx64: RTL
==================

Name: pcie_cpl_tx64

Overview:
- Completer-side TLP transmitter: turns a memory-read request descriptor plus its read data into a 3DW CplD TLP on the 64-bit Xilinx-style TX AXI-stream.
- Sits between the request decoder / local memory and the PCIe core TX interface.
- Header field layout and beat packing match the team's 64-bit TLP packing: beat0 = {hdr1, hdr0}; beat1 = {DW0, hdr2}; later beats = {DW(2k-2), DW(2k-3)}.

Parameters:
- MAX_LEN_DW, 128, maximum completion payload in DWs (legal req_len range is 1..MAX_LEN_DW).

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-high reset.
- completer_id  in  16  bus/dev/fn placed in hdr1[31:16].
- req_valid  in  1  descriptor valid.
- req_ready  out  1  descriptor accept.
- req_reqid  in  16  requester ID echoed in hdr2.
- req_tag  in  8  tag echoed in hdr2.
- req_len  in  10  payload length in DWs.
- req_lower_addr  in  7  lower address field.
- req_bytecount  in  12  byte count field.
- req_tc  in  3  traffic class.
- req_attr  in  2  attributes.
- rd_data  in  64  read data; [31:0] is the earlier DW.
- rd_valid  in  1  read data valid.
- rd_ready  out  1  read data accept.
- tx_tdata  out  64  TLP beat.
- tx_tkeep  out  8  byte enables.
- tx_tlast  out  1  last beat.
- tx_tvalid  out  1  beat valid.
- tx_tready  in  1  core ready.
- tx_tuser  out  4  tied to 0.
- err_len  out  1  one-cycle pulse when a request with an illegal length is dropped.

Behaviour:
- Reset: state IDLE; req_ready, rd_ready, tx_tvalid, tx_tlast, err_len, tx_tdata, tx_tkeep all 0. Reset mid-packet abandons the packet with no tlast.
- FSM states: IDLE, HDR0, HDR1, DATA.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all req_* fields and go to HDR0.
  - If req_len==0 or req_len>MAX_LEN_DW: accept the request, pulse err_len next cycle, stay in IDLE, emit nothing.
- HDR0:
  - tvalid=1, tkeep=FF.
  - tdata = {completer_id, cplsta=000, bcm=0, bytecount, 0, fmt=10, type=01010, 0, tc, 0000, td=0, ep=0, attr, 00, len}.
  - Go to HDR1 on tready.
- HDR1:
  - tvalid = rd_valid.
  - tdata = {rd_data[31:0], reqid, tag, 0, lower_addr}.
  - rd_ready = tready (meaning a handshake happens when tready && rd_valid).
  - On handshake: carry <= rd_data[63:32], rem <= len-1.
  - If len==1: tlast=1, tkeep=FF, go to IDLE. Otherwise go to DATA.
- DATA, rem>=2:
  - tvalid = rd_valid, tdata = {rd_data[31:0], carry}, tkeep=FF, rd_ready = tready.
  - On handshake: carry <= rd_data[63:32], rem -= 2.
  - If rem==2, tlast=1 and the upper DW of that rd word is discarded.
- DATA, rem==1:
  - tvalid=1, tdata = {32'h0, carry}, tkeep=0F, tlast=1, rd_ready=0.
- rem==0 after a handshake returns the FSM to IDLE.
- Beat count is ceil((3+len)/2); rd words consumed is ceil(len/2). Last-beat tkeep is 0F when len is even, FF when len is odd.
- AXIS rules:
  - tdata/tkeep/tlast are held stable while tvalid && !tready.
  - tvalid never depends on tready.
  - rd_ready is asserted only in HDR1/DATA with rem>=2.
- req_ready is 0 from acceptance until the cycle after the final beat handshake, so back-to-back packets have one idle cycle between them.
- rem is an 11-bit counter and never wraps, because of the len check in IDLE.

Optional Feature:
- Macro: PCIE_CPL_UR_EN.
- Defined:
  - Adds input req_ur (1 bit, latched with the descriptor).
  - When req_ur=1, emit a 2-beat Cpl: fmt=00, length=0, cplsta=001, bytecount taken from req_bytecount.
  - beat1 = {32'h0, hdr2}, tkeep=0F, tlast=1.
  - No rd_data is consumed, and the len check is skipped.
- Undefined: req_ur port is absent; every completion is a Successful CplD.

Test Plan:
- Single-DW completion. Stimulus: completer_id=0x0200, reqid=0x0100, tag=0x05, la=0x04, bc=4, len=1, tc=0, attr=0, rd_data=0x0-DDDDDDDD. Required: beat0 = 0x02000004_4A000001; beat1 = 0xDDDDDDDD_01000504 with tkeep=FF and tlast; one rd handshake.
- Even length. Stimulus: len=4, rd words {D1,D0},{D3,D2}. Required: 4 beats; beat2 = {D2,D1}; beat3 = {0,D3} with tkeep=0F and tlast; 2 rd handshakes.
- Odd length with discard. Stimulus: len=3. Required: beat2 = {D2,D1} with tkeep=FF and tlast; upper DW of rd word1 is discarded; FSM returns to IDLE.
- Backpressure and gaps. Stimulus: tready low for 3 cycles on beat1, and rd_valid low for 2 cycles mid-DATA. Required: tdata stable while stalled; rd_ready=0 while stalled; tvalid=0 during the gap; payload bit-exact.
- Back-to-back requests and illegal length. Stimulus: two back-to-back descriptors, then len=0. Required: second descriptor accepted only after the first packet's tlast handshake plus one cycle; len=0 gives an err_len pulse and no tvalid.
- Reset and UR. Stimulus: assert rst during DATA, then (with PCIE_CPL_UR_EN) a UR request with bc=8. Required: all outputs 0 immediately and FSM in IDLE; UR request gives beat0 = 0x02002008_0A000000 and beat1 with tkeep=0F and tlast.

Source files
------------

// File: rtl/pcie_cpl_tx64.sv
// 3DW CplD transmitter: turns a read descriptor plus read data into a TLP on a 64-bit TX AXI-stream.
// Optional PCIE_CPL_UR_EN adds req_ur_i, which makes the block emit a data-less UR completion instead.
module pcie_cpl_tx64 #(
    parameter int unsigned MAX_LEN_DW = 128
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] completer_id_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [15:0] req_reqid_i,
    input  logic [7:0]  req_tag_i,
    input  logic [9:0]  req_len_i,
    input  logic [6:0]  req_lower_addr_i,
    input  logic [11:0] req_bytecount_i,
    input  logic [2:0]  req_tc_i,
    input  logic [1:0]  req_attr_i,
`ifdef PCIE_CPL_UR_EN
    input  logic        req_ur_i,
`endif
    input  logic [63:0] rd_data_i,
    input  logic        rd_valid_i,
    output logic        rd_ready_o,
    output logic [63:0] tx_tdata_o,
    output logic [7:0]  tx_tkeep_o,
    output logic        tx_tlast_o,
    output logic        tx_tvalid_o,
    input  logic        tx_tready_i,
    output logic [3:0]  tx_tuser_o,
    output logic        err_len_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR0 = 2'd1;
    localparam logic [1:0] S_HDR1 = 2'd2;
    localparam logic [1:0] S_DATA = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [10:0] rem_q, rem_d;
    logic [31:0] carry_q, carry_d;
    logic        err_q, err_d;
    logic [15:0] reqid_q;
    logic [7:0]  tag_q;
    logic [9:0]  len_q;
    logic [6:0]  la_q;
    logic [11:0] bc_q;
    logic [2:0]  tc_q;
    logic [1:0]  attr_q;
    logic        ur_q;
    logic        ur_in, len_bad, accept, rd_hs;
    logic [31:0] hdr0, hdr1, hdr2;

`ifdef PCIE_CPL_UR_EN
    assign ur_in = req_ur_i;
`else
    assign ur_in = 1'b0;
`endif

    // UR completions carry no payload, so their length field is not range-checked.
    assign len_bad = !ur_in && ((req_len_i == '0) || (32'(req_len_i) > MAX_LEN_DW));
    assign accept  = req_valid_i && req_ready_o;
    assign rd_hs   = rd_valid_i && rd_ready_o;

    assign hdr0 = {1'b0, (ur_q ? 2'b00 : 2'b10), 5'b01010, 1'b0, tc_q, 4'b0000,
                   1'b0, 1'b0, attr_q, 2'b00, (ur_q ? 10'd0 : len_q)};
    assign hdr1 = {completer_id_i, (ur_q ? 3'b001 : 3'b000), 1'b0, bc_q};
    assign hdr2 = {reqid_q, tag_q, 1'b0, la_q};

    assign tx_tuser_o = '0;
    assign err_len_o  = err_q;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        carry_d     = carry_q;
        err_d       = 1'b0;
        req_ready_o = 1'b0;
        rd_ready_o  = 1'b0;
        tx_tvalid_o = 1'b0;
        tx_tlast_o  = 1'b0;
        tx_tdata_o  = '0;
        tx_tkeep_o  = '0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = !rst_i;
                if (accept) begin
                    err_d = len_bad;
                    if (!len_bad) state_d = S_HDR0;
                end
            end
            S_HDR0: begin
                tx_tvalid_o = 1'b1;
                tx_tkeep_o  = '1;
                tx_tdata_o  = {hdr1, hdr0};
                if (tx_tready_i) state_d = S_HDR1;
            end
            S_HDR1: begin
                if (ur_q) begin
                    tx_tvalid_o = 1'b1;
                    tx_tkeep_o  = 8'h0F;
                    tx_tlast_o  = 1'b1;
                    tx_tdata_o  = {32'h0, hdr2};
                    if (tx_tready_i) state_d = S_IDLE;
                end else begin
                    tx_tvalid_o = rd_valid_i;
                    tx_tkeep_o  = '1;
                    tx_tlast_o  = (len_q == 10'd1);
                    tx_tdata_o  = {rd_data_i[31:0], hdr2};
                    rd_ready_o  = tx_tready_i;
                    if (rd_hs) begin
                        carry_d = rd_data_i[63:32];
                        rem_d   = {1'b0, len_q} - 11'd1;
                        state_d = (len_q == 10'd1) ? S_IDLE : S_DATA;
                    end
                end
            end
            default: begin
                if (rem_q == 11'd1) begin
                    tx_tvalid_o = 1'b1;
                    tx_tkeep_o  = 8'h0F;
                    tx_tlast_o  = 1'b1;
                    tx_tdata_o  = {32'h0, carry_q};
                    if (tx_tready_i) begin
                        rem_d   = '0;
                        state_d = S_IDLE;
                    end
                end else begin
                    // With exactly two DWs left the upper DW of this rd word is past the end.
                    tx_tvalid_o = rd_valid_i;
                    tx_tkeep_o  = '1;
                    tx_tlast_o  = (rem_q == 11'd2);
                    tx_tdata_o  = {rd_data_i[31:0], carry_q};
                    rd_ready_o  = tx_tready_i;
                    if (rd_hs) begin
                        carry_d = rd_data_i[63:32];
                        rem_d   = rem_q - 11'd2;
                        if (rem_q == 11'd2) state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            carry_q <= '0;
            err_q   <= 1'b0;
            reqid_q <= '0;
            tag_q   <= '0;
            len_q   <= '0;
            la_q    <= '0;
            bc_q    <= '0;
            tc_q    <= '0;
            attr_q  <= '0;
            ur_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            if (accept) begin
                reqid_q <= req_reqid_i;
                tag_q   <= req_tag_i;
                len_q   <= req_len_i;
                la_q    <= req_lower_addr_i;
                bc_q    <= req_bytecount_i;
                tc_q    <= req_tc_i;
                attr_q  <= req_attr_i;
                ur_q    <= ur_in;
            end
        end
    end

endmodule
